// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// MULT is shift-add and DIV is restoring shift-subtract, one bit per cycle.
// Define MULT_DIV_SIGNED_EN for two's-complement MULT/DIV (default: unsigned).
module mult_div_unit #(
    parameter int Width = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [Width-1:0] Hi,
    output logic [Width-1:0] Lo
);
    localparam int CW = (Width > 1) ? $clog2(Width) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_div;
    logic                 r_busy;
    logic                 r_done;
    logic [Width-1:0]     r_m;
    logic [2*Width-1:0]   r_p;
    logic [Width-1:0]     r_hi;
    logic [Width-1:0]     r_lo;
    logic [Width:0]       w_sum;
    logic [Width:0]       w_rem;
    logic [Width:0]       w_sub;
    logic                 w_ge;
    logic [2*Width-1:0]   w_next;
    logic [2*Width-1:0]   w_res;
    logic [Width-1:0]     w_opa;
    logic [Width-1:0]     w_opb;
    logic                 w_accept;
`ifdef MULT_DIV_SIGNED_EN
    logic                 r_sq;
    logic                 r_sr;
`endif
    // One iteration step: shift-add for MULT, restoring shift-subtract for DIV
    always_comb begin
        w_sum    = {1'b0, r_p[2*Width-1:Width]} + {1'b0, r_m};
        w_rem    = r_p[2*Width-1:Width-1];
        w_ge     = w_rem >= {1'b0, r_m};
        w_sub    = w_rem - {1'b0, r_m};
        w_next   = r_div ? {w_ge ? w_sub[Width-1:0] : w_rem[Width-1:0], r_p[Width-2:0], w_ge}
                         : (r_p[0] ? {w_sum, r_p[Width-1:1]} : {1'b0, r_p[2*Width-1:1]});
        w_accept = Start && (r_state != RUN);
    end
`ifdef MULT_DIV_SIGNED_EN
    // Operands enter as magnitudes; signs are restored when the result is written
    always_comb begin
        w_opa = A[Width-1] ? -A : A;
        w_opb = B[Width-1] ? -B : B;
        w_res = r_div ? {r_sr ? -w_next[2*Width-1:Width] : w_next[2*Width-1:Width],
                         (r_sq && r_m != '0) ? -w_next[Width-1:0] : w_next[Width-1:0]}
                      : (r_sq ? -w_next : w_next);
    end
`else
    // Unsigned operation: operands and result pass through unchanged
    always_comb begin
        w_opa = A;
        w_opb = B;
        w_res = w_next;
    end
`endif
    // Control FSM, working registers and HI/LO; MTHI/MTLO write immediately
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_m     <= '0;
            r_p     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULT_DIV_SIGNED_EN
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
`endif
        end else if (w_accept && Op[1]) begin
            if (Op[0]) r_lo <= A;
            else       r_hi <= A;
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= Op[0];
            r_m     <= Op[0] ? w_opb : w_opa;
            r_p     <= {{Width{1'b0}}, Op[0] ? w_opa : w_opb};
`ifdef MULT_DIV_SIGNED_EN
            r_sq    <= A[Width-1] ^ B[Width-1];
            r_sr    <= A[Width-1];
`endif
        end else if (r_state == RUN) begin
            if (r_cnt == CW'(Width - 1)) begin
                {r_hi, r_lo} <= w_res;
                r_state      <= DONE;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
            end else begin
                r_p   <= w_next;
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (r_state == DONE) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end
    end
    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter Width, default 32, giving the operand and HI/LO register width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; it SHALL have port Clock, input, 1, the rising-edge clock.
REQ-003 The block SHALL have port Reset, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, the operation request, sampled on the rising edge of Clock.
REQ-005 The block SHALL have port Op, input, 2, the operation code: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 The block SHALL have port A, input, Width, dividend, multiplicand, or the MTHI/MTLO data.
REQ-007 The block SHALL have port B, input, Width, divisor or multiplier.
REQ-008 The block SHALL have port Busy, output, 1, high while an iterative operation is in progress.
REQ-009 The block SHALL have port Done, output, 1, a one-cycle pulse marking that Hi/Lo hold a new result.
REQ-010 The block SHALL have port Hi, output, Width, the HI register (product upper half or remainder).
REQ-011 The block SHALL have port Lo, output, Width, the LO register (product lower half or quotient).

Function
REQ-012 The block SHALL have states IDLE, RUN and DONE; Busy SHALL be 1 only in RUN, and Done SHALL be 1 only in DONE.
REQ-013 Start SHALL be accepted only in IDLE or DONE; Start while in RUN SHALL be ignored with no state or register change.
REQ-014 On accepting MULT or DIV at edge N, the block SHALL latch A, B and Op, clear its iteration counter, and enter RUN; A/B changes after edge N SHALL have no effect.
REQ-015 RUN SHALL perform one iteration per cycle: shift-add for MULT, restoring shift-subtract for DIV.
REQ-016 After Width iterations, at edge N+Width, the block SHALL write Hi/Lo and enter DONE, so Done is high in the cycle after edge N+Width.
REQ-017 From DONE, the block SHALL go to IDLE on the next edge, unless a new Start is accepted on that edge.
REQ-018 MULT SHALL produce {Hi,Lo} = the full 2*Width-bit product.
REQ-019 DIV SHALL produce Lo = quotient truncated toward zero and Hi = remainder, with the remainder sign equal to the dividend sign.
REQ-020 DIV by zero SHALL take the full latency and give Hi = A and Lo = all ones.
REQ-021 Signed DIV of the most-negative value by -1 SHALL give Lo = most-negative value and Hi = 0.
REQ-022 MTHI or MTLO accepted at edge N SHALL write A into Hi or Lo at edge N, with no Busy and no Done.
REQ-023 Hi/Lo SHALL hold their values at all times other than those in REQ-016 and REQ-022.

Reset
REQ-024 When Reset is 1 at a rising edge, the block SHALL set state to IDLE, Busy = 0, Done = 0, Hi = 0, Lo = 0, and clear the counter and latched operands.
REQ-025 Reset asserted mid-RUN SHALL abort the operation: no Done pulse and no partial result written.
REQ-026 Reset SHALL take priority over Start on the same edge.

Configuration
REQ-027 The macro SHALL be MULT_DIV_SIGNED_EN.
REQ-028 With MULT_DIV_SIGNED_EN defined, MULT and DIV SHALL treat A and B as two's complement, using magnitudes and a final sign correction in DONE entry with no added latency.
REQ-029 With MULT_DIV_SIGNED_EN undefined, MULT and DIV SHALL be unsigned, REQ-021 SHALL not apply, and the sign-correction logic SHALL be absent.

Verification
REQ-030 The bench SHALL check: DIV A=11, B=3 -> Busy high 32 cycles, Done pulse once, Hi=2, Lo=3.
REQ-031 The bench SHALL check: MULT A=32'hFFFFFFFF, B=1 -> signed Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFF; with the macro off, Hi=0, Lo=32'hFFFFFFFF.
REQ-032 The bench SHALL check: signed DIV A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIV A=7, B=0 -> Hi=7, Lo=32'hFFFFFFFF.
REQ-033 The bench SHALL check: DIV A=10, B=3 with Reset pulsed at RUN cycle 10 -> Busy=0 next cycle, Hi=Lo=0, no Done.
REQ-034 The bench SHALL check: MULT started, then Start with DIV at RUN cycle 5 -> ignored, MULT result delivered at the original cycle.
REQ-035 The bench SHALL check: MTHI A=32'h1234 in IDLE -> Hi=32'h1234 after one edge, Busy/Done stay 0, Lo unchanged.
REQ-036 The bench SHALL check: a new Start accepted in DONE -> back-to-back operation with no idle cycle.
